// File: rtl/mem_stage.sv
// MEM pipeline stage: load byte/half/word extraction, branch redirect at MEM,
// and a two-state wait FSM that freezes the front end while a load is outstanding.
module mem_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        in_valid,
   input  logic        in_regWrite,
   input  logic        in_memToReg,
   input  logic        in_memRead,
   input  logic        in_isDMByte,
   input  logic        in_isDMHalf,
   input  logic        in_isDMSigned,
   input  logic [29:0] in_pcp1,
   input  logic [4:0]  in_rw,
   input  logic [31:0] in_exout,
   input  logic [2:0]  in_branchType,
   input  logic        in_branchCommit,
   input  logic        in_branchAvail,
   input  logic [31:0] in_dmout,
   input  logic        dm_ready,
   input  logic [31:0] dm_rdata,
   output logic        mem_stall,
   output logic        correctAtMEM,
   output logic [29:0] correctPCAtMEM,
   output logic        wb_regWrite,
   output logic        wb_memToReg,
   output logic [4:0]  wb_rw,
   output logic [31:0] wb_data,
   output logic [37:0] bypass_mem
);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t      r_state;
   state_t      w_nextState;
   logic        w_loadReq;
   logic        w_stall;
   logic [31:0] w_loadWord;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_loadData;
   logic [31:0] w_wbData;
   logic        r_wbRegWrite;
   logic        r_wbMemToReg;
   logic [4:0]  r_wbRw;
   logic [31:0] r_wbData;

   assign w_loadReq = in_valid & in_memRead;

   // Gated by rst so the pipeline never sees a stall or redirect during reset.
   always_comb begin
      w_stall = 1'b0;
      if (rst) begin
         if (r_state == S_IDLE)
            w_stall = w_loadReq & ~dm_ready;
         else
            w_stall = ~dm_ready;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE: if (w_loadReq & ~dm_ready & ~flush) w_nextState = S_WAIT;
         S_WAIT: if (dm_ready | flush) w_nextState = S_IDLE;
         default: w_nextState = S_IDLE;
      endcase
   end

   // A load finishing after a wait takes the late bus word instead of the EX launch.
   always_comb begin
      w_loadWord = (r_state == S_WAIT) ? dm_rdata : in_dmout;
      case (in_exout[1:0])
         2'd0:    w_byte = w_loadWord[7:0];
         2'd1:    w_byte = w_loadWord[15:8];
         2'd2:    w_byte = w_loadWord[23:16];
         default: w_byte = w_loadWord[31:24];
      endcase
      w_half = in_exout[1] ? w_loadWord[31:16] : w_loadWord[15:0];
      if (in_isDMByte)
         w_loadData = {{24{in_isDMSigned & w_byte[7]}}, w_byte};
      else if (in_isDMHalf)
         w_loadData = {{16{in_isDMSigned & w_half[15]}}, w_half};
      else
         w_loadData = w_loadWord;
      w_wbData = in_memToReg ? w_loadData : in_exout;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_wbRegWrite <= 1'b0;
         r_wbMemToReg <= 1'b0;
         r_wbRw       <= 5'd0;
         r_wbData     <= 32'd0;
      end else begin
         r_state <= w_nextState;
         if (flush | w_stall) begin
            r_wbRegWrite <= 1'b0;
            r_wbMemToReg <= 1'b0;
         end else begin
            r_wbRegWrite <= in_regWrite & in_valid;
            r_wbMemToReg <= in_memToReg;
            r_wbRw       <= in_rw;
            r_wbData     <= w_wbData;
         end
      end
   end

   assign mem_stall      = w_stall;
   assign correctAtMEM   = rst & in_valid & in_branchCommit & (in_branchType != 3'd0) &
                           in_branchAvail & ~w_stall;
   assign correctPCAtMEM = in_pcp1 + in_exout[31:2];
   assign wb_regWrite    = r_wbRegWrite;
   assign wb_memToReg    = r_wbMemToReg;
   assign wb_rw          = r_wbRw;
   assign wb_data        = r_wbData;
   assign bypass_mem     = {in_regWrite, in_rw, in_exout};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, hand-written
// multi-cycle sequences, and random transactions against a behavioural model.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid, in_regWrite, in_memToReg, in_memRead;
   logic        in_isDMByte, in_isDMHalf, in_isDMSigned;
   logic [29:0] in_pcp1;
   logic [4:0]  in_rw;
   logic [31:0] in_exout;
   logic [2:0]  in_branchType;
   logic        in_branchCommit, in_branchAvail;
   logic [31:0] in_dmout;
   logic        dm_ready;
   logic [31:0] dm_rdata;
   logic        mem_stall, correctAtMEM;
   logic [29:0] correctPCAtMEM;
   logic        wb_regWrite, wb_memToReg;
   logic [4:0]  wb_rw;
   logic [31:0] wb_data;
   logic [37:0] bypass_mem;

   int totalCount = 0;
   int badCount   = 0;

   typedef struct {
      logic        valid, regWrite, memToReg, memRead, isByte, isHalf, isSigned;
      logic [29:0] pcp1;
      logic [4:0]  rw;
      logic [31:0] exout;
      logic [2:0]  brType;
      logic        brCommit, brAvail;
      logic [31:0] dmout;
      logic        expCorrect;
      logic [29:0] expPC;
      logic        expRegWrite;
      logic [31:0] expData;
   } vec_t;

   vec_t vecs[12];

   mem_stage dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_regWrite(in_regWrite), .in_memToReg(in_memToReg),
      .in_memRead(in_memRead), .in_isDMByte(in_isDMByte), .in_isDMHalf(in_isDMHalf),
      .in_isDMSigned(in_isDMSigned), .in_pcp1(in_pcp1), .in_rw(in_rw),
      .in_exout(in_exout), .in_branchType(in_branchType),
      .in_branchCommit(in_branchCommit), .in_branchAvail(in_branchAvail),
      .in_dmout(in_dmout), .dm_ready(dm_ready), .dm_rdata(dm_rdata),
      .mem_stall(mem_stall), .correctAtMEM(correctAtMEM),
      .correctPCAtMEM(correctPCAtMEM), .wb_regWrite(wb_regWrite),
      .wb_memToReg(wb_memToReg), .wb_rw(wb_rw), .wb_data(wb_data),
      .bypass_mem(bypass_mem)
   );

   always #5 clk = ~clk;

   function automatic vec_t clearVec();
      vec_t v;
      v = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 30'd0, 5'd0, 32'd0, 3'd0,
            1'b0, 1'b0, 32'd0, 1'b0, 30'd0, 1'b0, 32'd0};
      return v;
   endfunction

   // Load extraction from the rules: shift the addressed lane down, mask, then sign-adjust.
   function automatic logic [31:0] modelLoad(input logic [31:0] word, input logic [31:0] addr,
                                             input logic isByte, input logic isHalf,
                                             input logic isSigned);
      int unsigned v;
      if (isByte) begin
         v = (word >> (8 * addr[1:0])) & 32'hFF;
         if (isSigned && v >= 128) v = v - 256;
      end else if (isHalf) begin
         v = (word >> (16 * addr[1])) & 32'hFFFF;
         if (isSigned && v >= 32768) v = v - 65536;
      end else begin
         v = word;
      end
      return v;
   endfunction

   task automatic applyStimulus(input vec_t v, input logic rdy, input logic fl,
                                input logic [31:0] rdata);
      in_valid        = v.valid;
      in_regWrite     = v.regWrite;
      in_memToReg     = v.memToReg;
      in_memRead      = v.memRead;
      in_isDMByte     = v.isByte;
      in_isDMHalf     = v.isHalf;
      in_isDMSigned   = v.isSigned;
      in_pcp1         = v.pcp1;
      in_rw           = v.rw;
      in_exout        = v.exout;
      in_branchType   = v.brType;
      in_branchCommit = v.brCommit;
      in_branchAvail  = v.brAvail;
      in_dmout        = v.dmout;
      dm_ready        = rdy;
      flush           = fl;
      dm_rdata        = rdata;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      totalCount++;
      if (actual !== expected) begin
         badCount++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   initial begin
      vec_t v;
      logic [31:0] rdata, expWord;
      int waitN;
      logic expCorr;

      // valid regWr m2r mRd byte half sgn pcp1 rw exout brT com avl dmout | corr PC regWr data
      vecs[0]  = '{1,1,1,1,1,0,1, 30'h0,        5'd3,  32'h00001002, 3'd0,0,0, 32'h12F45678, 0, 30'h400,      1, 32'hFFFFFFF4};
      vecs[1]  = '{1,1,0,0,0,0,0, 30'h20,       5'd7,  32'hDEADBEEF, 3'd0,0,0, 32'h0,        0, 30'h37AB6FDB, 1, 32'hDEADBEEF};
      vecs[2]  = '{1,0,0,0,0,0,0, 30'h100,      5'd0,  32'h00000010, 3'd1,1,1, 32'h0,        1, 30'h104,      0, 32'h00000010};
      vecs[3]  = '{1,1,1,1,1,0,0, 30'h0,        5'd4,  32'h00000003, 3'd0,0,0, 32'h12F45678, 0, 30'h0,        1, 32'h00000012};
      vecs[4]  = '{1,1,1,1,0,1,1, 30'h5,        5'd5,  32'h00000000, 3'd0,0,0, 32'h12348765, 0, 30'h5,        1, 32'hFFFF8765};
      vecs[5]  = '{1,1,1,1,0,1,0, 30'h10,       5'd6,  32'h00000002, 3'd0,0,0, 32'h8001ABCD, 0, 30'h10,       1, 32'h00008001};
      vecs[6]  = '{1,1,1,1,0,0,0, 30'h0,        5'd8,  32'h00000004, 3'd0,0,0, 32'hCAFEF00D, 0, 30'h1,        1, 32'hCAFEF00D};
      vecs[7]  = '{0,1,0,0,0,0,0, 30'h100,      5'd9,  32'h00000040, 3'd2,1,1, 32'h0,        0, 30'h110,      0, 32'h00000040};
      vecs[8]  = '{1,0,0,0,0,0,0, 30'h3FFFFFFF, 5'd0,  32'h00000008, 3'd3,1,1, 32'h0,        1, 30'h1,        0, 32'h00000008};
      vecs[9]  = '{1,0,0,0,0,0,0, 30'h200,      5'd0,  32'h00000020, 3'd0,1,1, 32'h0,        0, 30'h208,      0, 32'h00000020};
      vecs[10] = '{1,1,1,1,1,0,1, 30'h0,        5'd10, 32'h00000005, 3'd0,0,0, 32'h00007F00, 0, 30'h1,        1, 32'h0000007F};
      vecs[11] = '{1,1,0,0,0,0,0, 30'h8,        5'd11, 32'h0000000C, 3'd4,1,0, 32'h0,        0, 30'hB,        1, 32'h0000000C};

      // Reset with a pending load and a live branch: everything must stay quiet.
      rst = 1'b0;
      v = clearVec();
      v.valid = 1; v.memRead = 1; v.brType = 3'd1; v.brCommit = 1; v.brAvail = 1;
      applyStimulus(v, 1'b0, 1'b0, 32'h0);
      #1;
      checkOutput("rst_stall", {63'd0, mem_stall}, 64'd0);
      checkOutput("rst_correct", {63'd0, correctAtMEM}, 64'd0);
      @(posedge clk); #1;
      checkOutput("rst_wb", {25'd0, wb_regWrite, wb_memToReg, wb_rw, wb_data}, 64'd0);
      @(negedge clk);
      applyStimulus(clearVec(), 1'b1, 1'b0, 32'h0);
      rst = 1'b1;

      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         applyStimulus(vecs[i], 1'b1, 1'b0, 32'h0);
         #1;
         checkOutput($sformatf("vec%0d_stall", i), {63'd0, mem_stall}, 64'd0);
         checkOutput($sformatf("vec%0d_correct", i), {63'd0, correctAtMEM}, {63'd0, vecs[i].expCorrect});
         checkOutput($sformatf("vec%0d_pc", i), {34'd0, correctPCAtMEM}, {34'd0, vecs[i].expPC});
         checkOutput($sformatf("vec%0d_bypass", i), {26'd0, bypass_mem},
                     {26'd0, vecs[i].regWrite, vecs[i].rw, vecs[i].exout});
         @(posedge clk); #1;
         checkOutput($sformatf("vec%0d_regWrite", i), {63'd0, wb_regWrite}, {63'd0, vecs[i].expRegWrite});
         checkOutput($sformatf("vec%0d_memToReg", i), {63'd0, wb_memToReg}, {63'd0, vecs[i].memToReg});
         checkOutput($sformatf("vec%0d_rw", i), {59'd0, wb_rw}, {59'd0, vecs[i].rw});
         checkOutput($sformatf("vec%0d_data", i), {32'd0, wb_data}, {32'd0, vecs[i].expData});
      end

      // Unsigned half load with two wait cycles.
      v = clearVec();
      v.valid = 1; v.regWrite = 1; v.memToReg = 1; v.memRead = 1; v.isHalf = 1;
      v.rw = 5'd12; v.exout = 32'h2002; v.dmout = 32'h11112222;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         applyStimulus(v, (c == 2), 1'b0, (c == 2) ? 32'h8001ABCD : 32'h5A5A5A5A);
         #1;
         checkOutput($sformatf("half_wait_stall%0d", c), {63'd0, mem_stall}, {63'd0, (c < 2)});
         @(posedge clk); #1;
         checkOutput($sformatf("half_wait_regWrite%0d", c), {63'd0, wb_regWrite}, {63'd0, (c == 2)});
      end
      checkOutput("half_wait_data", {32'd0, wb_data}, 64'h00008001);

      // Flush in the second wait cycle returns the FSM to idle.
      @(negedge clk);
      applyStimulus(v, 1'b0, 1'b0, 32'h0);
      #1;
      checkOutput("flushwait_stall0", {63'd0, mem_stall}, 64'd1);
      @(negedge clk);
      applyStimulus(v, 1'b0, 1'b1, 32'h0);
      #1;
      checkOutput("flushwait_stall1", {63'd0, mem_stall}, 64'd1);
      @(posedge clk); #1;
      checkOutput("flushwait_regWrite", {63'd0, wb_regWrite}, 64'd0);
      @(negedge clk);
      applyStimulus(clearVec(), 1'b0, 1'b0, 32'h0);
      #1;
      checkOutput("flushwait_idle", {63'd0, mem_stall}, 64'd0);

      // Flush kills an ALU write that would otherwise retire.
      v = clearVec();
      v.valid = 1; v.regWrite = 1; v.rw = 5'd9; v.exout = 32'h55;
      @(negedge clk);
      applyStimulus(v, 1'b1, 1'b0, 32'h0);
      @(posedge clk); #1;
      checkOutput("flushalu_pre", {63'd0, wb_regWrite}, 64'd1);
      @(negedge clk);
      applyStimulus(v, 1'b1, 1'b1, 32'h0);
      @(posedge clk); #1;
      checkOutput("flushalu_regWrite", {63'd0, wb_regWrite}, 64'd0);

      // Reset in the middle of a wait abandons the load.
      v = clearVec();
      v.valid = 1; v.regWrite = 1; v.memToReg = 1; v.memRead = 1; v.rw = 5'd13; v.exout = 32'h40;
      @(negedge clk);
      applyStimulus(v, 1'b0, 1'b0, 32'h0);
      @(posedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      checkOutput("rstwait_outs", {23'd0, mem_stall, correctAtMEM, wb_regWrite, wb_memToReg,
                                   wb_rw, wb_data}, 64'd0);
      @(negedge clk);
      applyStimulus(clearVec(), 1'b0, 1'b0, 32'h0);
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         checkOutput($sformatf("rstwait_stall%0d", c), {63'd0, mem_stall}, 64'd0);
         @(posedge clk); #1;
         checkOutput($sformatf("rstwait_regWrite%0d", c), {63'd0, wb_regWrite}, 64'd0);
         @(negedge clk);
      end

      // Random transactions against the behavioural model.
      for (int t = 0; t < 80; t++) begin
         int kind;
         kind = $urandom_range(0, 2);
         v = clearVec();
         v.valid    = ($urandom_range(0, 7) != 0);
         v.regWrite = $urandom_range(0, 1);
         v.memRead  = (kind == 1);
         v.memToReg = (kind == 1);
         case ($urandom_range(0, 2))
            0: v.isByte = 1;
            1: v.isHalf = 1;
            default: ;
         endcase
         v.isSigned = $urandom_range(0, 1);
         v.pcp1     = {$urandom} & 32'h3FFFFFFF;
         v.rw       = $urandom_range(0, 31);
         v.exout    = $urandom;
         v.brType   = (kind == 2) ? 3'($urandom_range(0, 7)) : 3'd0;
         v.brCommit = $urandom_range(0, 1);
         v.brAvail  = $urandom_range(0, 1);
         v.dmout    = $urandom;
         rdata      = $urandom;
         waitN      = (v.valid && v.memRead) ? $urandom_range(0, 3) : 0;
         expWord    = (waitN == 0) ? v.dmout : rdata;
         for (int c = 0; c <= waitN; c++) begin
            @(negedge clk);
            applyStimulus(v, (c == waitN), 1'b0, (c == waitN) ? rdata : $urandom);
            #1;
            expCorr = (c == waitN) && v.valid && v.brCommit && (v.brType != 0) && v.brAvail;
            checkOutput($sformatf("rnd%0d_stall%0d", t, c), {63'd0, mem_stall}, {63'd0, (c < waitN)});
            checkOutput($sformatf("rnd%0d_correct%0d", t, c), {63'd0, correctAtMEM}, {63'd0, expCorr});
            checkOutput($sformatf("rnd%0d_pc", t), {34'd0, correctPCAtMEM},
                        {32'd0, (v.pcp1 + (v.exout >> 2)) & 32'h3FFFFFFF});
            @(posedge clk); #1;
            if (c < waitN) begin
               checkOutput($sformatf("rnd%0d_bubble%0d", t, c), {63'd0, wb_regWrite}, 64'd0);
            end else begin
               checkOutput($sformatf("rnd%0d_regWrite", t), {63'd0, wb_regWrite},
                           {63'd0, v.regWrite & v.valid});
               checkOutput($sformatf("rnd%0d_memToReg", t), {63'd0, wb_memToReg}, {63'd0, v.memToReg});
               checkOutput($sformatf("rnd%0d_rw", t), {59'd0, wb_rw}, {59'd0, v.rw});
               checkOutput($sformatf("rnd%0d_data", t), {32'd0, wb_data},
                           {32'd0, v.memToReg ? modelLoad(expWord, v.exout, v.isByte, v.isHalf,
                                                          v.isSigned) : v.exout});
            end
         end
      end

      $display("test done: total=%0d bad=%0d", totalCount, badCount);
      $finish;
   end

endmodule
